// File: rtl/led_scan4_pkg.sv
// Shared definitions for the four-digit multiplexed LED scanner.
//   SEG_TABLE   : active-low segment codes for hex 0..F, bit order g,f,e,d,c,b,a
//   SEG_OFF     : all segments dark
//   AN_OFF      : all digit enables inactive
//   presc_width : counter width that can hold 0..presc-1
package led_scan4_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Lowercase glyphs are used for b and d so they stay distinct from 8 and 0.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    localparam int PRESC_DEFAULT = 16;

    function automatic int presc_width(input int presc);
        return (presc <= 2) ? 1 : $clog2(presc);
    endfunction

    localparam int PCNT_W_DEFAULT = presc_width(PRESC_DEFAULT);

endpackage

// File: rtl/led_scan4_hex_to_seg7.sv
// Combinational hex to seven-segment decoder.
//   nib : 4-bit hex value
//   seg : active-low segments, bit order g,f,e,d,c,b,a
module hex_to_seg7
    import led_scan4_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/led_scan4.sv
// Four-digit time-multiplexed seven-segment scanner with snapshot register,
// optional leading-zero blanking and a one-cycle dark gap per slot.
//   clk   : clock, rising edge
//   clr   : synchronous active-low reset
//   dat   : four hex digits, dat[3:0] is the rightmost digit
//   ld    : snapshot strobe for dat and dp_in
//   dp_in : decimal point request per digit (1 = lit)
//   blank : suppress leading zeros (live input)
//   an    : active-low digit enables
//   seg   : active-low segments g..a
//   dp    : active-low decimal point
//   tick  : one-cycle pulse on each digit-slot change
module led_scan4
    import led_scan4_pkg::*;
#(
    parameter int PRESC = PRESC_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] dat,
    input  logic        ld,
    input  logic [3:0]  dp_in,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        tick
);

    localparam int            PW        = presc_width(PRESC);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESC - 1);

    logic [PW-1:0] pcnt_reg;
    logic [1:0]    dig_reg;
    logic [15:0]   snap_reg;
    logic [3:0]    dps_reg;
    logic          tick_reg;
    logic [3:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;

    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    logic [3:0]    nib_sel;
    logic [6:0]    seg_code;
    logic [3:0]    lead_zero;
    logic          slot_end;
    logic          digit_dark;

    // Digit i is a leading zero when it and every digit above it are zero.
    // The rightmost digit always shows, so its flag is tied low.
    assign lead_zero[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
            assign lead_zero[gi] = (snap_reg[15:4*gi] == '0);
        end
    endgenerate

    assign nib_sel  = snap_reg[{dig_reg, 2'b00} +: 4];
    assign slot_end = (pcnt_reg == PCNT_LAST);

    hex_to_seg7 u_dec (
        .nib (nib_sel),
        .seg (seg_code)
    );

    // First cycle of every slot is dark so the previous digit's pattern
    // never bleeds onto the newly enabled anode.
    always_comb begin
        digit_dark = (pcnt_reg == '0) || (blank && lead_zero[dig_reg]);
        an_next    = AN_OFF;
        seg_next   = SEG_OFF;
        dp_next    = 1'b1;
        if (!digit_dark) begin
            an_next  = ~(4'b0001 << dig_reg);
            seg_next = seg_code;
            dp_next  = ~dps_reg[dig_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            pcnt_reg <= '0;
            dig_reg  <= '0;
            snap_reg <= '0;
            dps_reg  <= '0;
            tick_reg <= 1'b0;
            an_reg   <= AN_OFF;
            seg_reg  <= SEG_OFF;
            dp_reg   <= 1'b1;
        end else begin
            pcnt_reg <= slot_end ? '0 : pcnt_reg + 1'b1;
            tick_reg <= slot_end;
            if (slot_end) begin
                dig_reg <= dig_reg + 2'd1;
            end
            if (ld) begin
                snap_reg <= dat;
                dps_reg  <= dp_in;
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign an   = an_reg;
    assign seg  = seg_reg;
    assign dp   = dp_reg;
    assign tick = tick_reg;

endmodule
